ysyx_23060096_rf_wb_arbiter: RTL and testbench
==============================================

YSYX_23060096_RF_WB_ARBITER -- requirements
Module: ysyx_23060096_rf_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on posedge clk.
REQ-004 SHALL have port rstn, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port issue_valid, input, 1, decode issues an instruction that writes issue_rd.
REQ-006 SHALL have port issue_rd, input, ADDR_WIDTH, destination register of the issuing instruction.
REQ-007 SHALL have port issue_ready, output, 1, issue accepted this cycle.
REQ-008 SHALL have ports rs1/rs2, input, ADDR_WIDTH each, source registers being read by decode.
REQ-009 SHALL have ports rs1_busy/rs2_busy, output, 1 each, source has a pending write.
REQ-010 SHALL have ports exu_valid, input, 1; exu_rd, input, ADDR_WIDTH; exu_data, input, DATA_WIDTH; exu_ready, output, 1: ALU writeback request.
REQ-011 SHALL have ports lsu_valid, input, 1; lsu_rd, input, ADDR_WIDTH; lsu_data, input, DATA_WIDTH; lsu_ready, output, 1: load writeback request.
REQ-012 SHALL have ports rf_wen, output, 1; rf_waddr, output, ADDR_WIDTH; rf_wdata, output, DATA_WIDTH: drive the register file's single write port.

Function
REQ-013 SHALL keep a 2^ADDR_WIDTH-bit scoreboard busy[]; bit 0 is constant 0.
REQ-014 SHALL assert issue_ready = !busy[issue_rd] (WAW stall); issue with issue_rd = 0 is always ready and sets nothing.
REQ-015 SHALL set busy[issue_rd] on posedge when issue_valid && issue_ready && issue_rd != 0.
REQ-016 SHALL drive rsN_busy = busy[rsN] combinationally; rsN = 0 gives 0.
REQ-017 SHALL grant at most one requester per cycle; a transfer is valid && ready in the same cycle.
REQ-018 SHALL grant a lone valid requester in the same cycle (zero-latency, combinational ready).
REQ-019 SHALL, when both are valid, grant the requester not granted in the last contended cycle (round-robin); last_grant updates only on contended cycles.
REQ-020 SHALL drive rf_waddr/rf_wdata from the granted requester and rf_wen = transfer && rd != 0; with no grant, rf_wen = 0 and waddr/wdata = 0.
REQ-021 SHALL complete the handshake for rd = 0 (ready high) without writing the register file.
REQ-022 SHALL clear busy[rd] on posedge of a completed transfer with rd != 0.
REQ-023 SHALL, on same-cycle clear of busy[r] and issue to r, keep issue blocked (busy sampled pre-clear); issue succeeds next cycle.
REQ-024 SHALL allow issue to register a and writeback clear of register b != a in the same cycle, both taking effect.
REQ-025 SHALL require requesters to hold rd/data stable while valid && !ready; the arbiter does not buffer data.
REQ-026 SHALL flag in simulation (assertion) a writeback to a register whose busy bit is 0.

Reset
REQ-027 SHALL, while rstn = 0, clear all busy bits and set last_grant = LSU (EXU wins the first contention), independent of clk.
REQ-028 SHALL hold rf_wen, exu_ready, lsu_ready at 0 while rstn = 0; issue_ready reads 1.
REQ-029 SHALL discard any in-flight request on reset; requesters deassert valid during reset.

Structure
REQ-030 SHALL place the requester encoding (REQ_EXU = 0, REQ_LSU = 1) and the default widths in the shared ysyx_23060096 package.
REQ-031 SHALL implement the scoreboard as sub-module ysyx_23060096_scoreboard (set port, clear port, two read ports); the arbiter stays in the top level.
REQ-032 SHALL connect directly to ysyx_23060096_RegisterFile write-port inputs with no added pipeline stage.

Verification
REQ-033 SHALL test a single writeback: issue rd=5, then exu_valid rd=5 data=0xDEADBEEF -> rf_wen=1, waddr=5, wdata=0xDEADBEEF the same cycle; busy[5]=0 next cycle.
REQ-034 SHALL test contention: both valid (rd=3, rd=4) for 3 cycles after reset -> grants EXU, LSU, EXU; the loser's ready is 0 each cycle.
REQ-035 SHALL test x0: lsu_valid rd=0 -> lsu_ready=1, rf_wen=0, scoreboard unchanged.
REQ-036 SHALL test hazard: issue rd=7, rs1=7 -> rs1_busy=1 until the writeback to 7 completes, then 0 the next cycle; a second issue to rd=7 is stalled until then.
REQ-037 SHALL test simultaneous events: a clear of 9 with an issue to 9 -> issue_ready=0, accepted next cycle; a clear of 9 with an issue to 10 -> busy[9]=0 and busy[10]=1.
REQ-038 SHALL test reset mid-operation: busy[1..31] set, rstn pulsed low asynchronously -> all busy=0 and readies=0 immediately; the first contention after release grants EXU.

Source files
------------

// File: rtl/ysyx_23060096_pkg.sv
// Shared encodings and default widths for the ysyx_23060096 core.
package ysyx_23060096_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic {
    REQ_EXU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

endpackage

// File: rtl/ysyx_23060096_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
module ysyx_23060096_scoreboard
  import ysyx_23060096_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  set_en_i,
  input  logic [ADDR_WIDTH-1:0] set_addr_i,
  output logic                  set_busy_o,
  input  logic                  clr_en_i,
  input  logic [ADDR_WIDTH-1:0] clr_addr_i,
  input  logic [ADDR_WIDTH-1:0] rd0_addr_i,
  output logic                  rd0_busy_o,
  input  logic [ADDR_WIDTH-1:0] rd1_addr_i,
  output logic                  rd1_busy_o
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [NREGS-1:0] busy_q, busy_d;

  // Set and clear never target the same register: a set requires the bit
  // to be clear beforehand, a clear requires it to be set.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Readers see the pre-update value, so a same-cycle clear does not unblock.
  assign set_busy_o = busy_q[set_addr_i];
  assign rd0_busy_o = busy_q[rd0_addr_i];
  assign rd1_busy_o = busy_q[rd1_addr_i];

  a_clr_of_idle_reg: assert property (@(posedge clk) disable iff (!rstn)
    (clr_en_i && clr_addr_i != '0) |-> busy_q[clr_addr_i]);

endmodule

// File: rtl/ysyx_23060096_rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin EXU/LSU onto the single RF
// write port, plus the scoreboard that stalls WAW issues and flags RAW sources.
module ysyx_23060096_rf_wb_arbiter
  import ysyx_23060096_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  exu_valid,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  output logic                  exu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  req_e                  last_q, last_d;
  logic                  contend;
  logic                  gnt_exu, gnt_lsu, wb_vld;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  issue_busy;

  assign contend = exu_valid && lsu_valid;

  // Readies are gated by rstn so nothing transfers while reset is held.
  always_comb begin
    gnt_exu = 1'b0;
    gnt_lsu = 1'b0;
    if (rstn) begin
      gnt_exu = exu_valid && (!lsu_valid || last_q == REQ_LSU);
      gnt_lsu = lsu_valid && (!exu_valid || last_q == REQ_EXU);
    end
  end

  always_comb begin
    last_d = last_q;
    if (contend) last_d = gnt_exu ? REQ_EXU : REQ_LSU;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) last_q <= REQ_LSU;
    else       last_q <= last_d;
  end

  always_comb begin
    wb_vld  = gnt_exu || gnt_lsu;
    wb_rd   = '0;
    wb_data = '0;
    if (gnt_exu) begin
      wb_rd   = exu_rd;
      wb_data = exu_data;
    end else if (gnt_lsu) begin
      wb_rd   = lsu_rd;
      wb_data = lsu_data;
    end
  end

  assign exu_ready = gnt_exu;
  assign lsu_ready = gnt_lsu;
  assign rf_wen    = wb_vld && (wb_rd != '0);
  assign rf_waddr  = wb_rd;
  assign rf_wdata  = wb_data;

  assign issue_ready = !issue_busy;

  ysyx_23060096_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sb (
    .clk       (clk),
    .rstn      (rstn),
    .set_en_i  (issue_valid && issue_ready && (issue_rd != '0)),
    .set_addr_i(issue_rd),
    .set_busy_o(issue_busy),
    .clr_en_i  (rf_wen),
    .clr_addr_i(wb_rd),
    .rd0_addr_i(rs1),
    .rd0_busy_o(rs1_busy),
    .rd1_addr_i(rs2),
    .rd1_busy_o(rs2_busy)
  );

endmodule

// File: tb/tb_ysyx_23060096_rf_wb_arbiter.sv
// Directed bench for the RF writeback arbiter and its scoreboard.
module tb_ysyx_23060096_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        exu_valid;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        exu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  ysyx_23060096_rf_wb_arbiter dut (
    .clk        (clk),
    .rstn       (rstn),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .exu_valid  (exu_valid),
    .exu_rd     (exu_rd),
    .exu_data   (exu_data),
    .exu_ready  (exu_ready),
    .lsu_valid  (lsu_valid),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .lsu_ready  (lsu_ready),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [4:0] r);
    issue_valid = 1'b1;
    issue_rd    = r;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic do_wb(input logic [4:0] r);
    exu_valid = 1'b1;
    exu_rd    = r;
    exu_data  = 32'h1111_0000;
    tick();
    exu_valid = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h5;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h6;
    issue_valid = 1'b0; issue_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd6;
    #2;
    total++; if (issue_ready !== 1'b1) $display("FAIL reset_issue_ready got %b exp 1", issue_ready); else pass_cnt++;
    total++; if (exu_ready !== 1'b0 || lsu_ready !== 1'b0)
      $display("FAIL reset_readies got exu=%b lsu=%b exp 0/0", exu_ready, lsu_ready); else pass_cnt++;
    total++; if (rf_wen !== 1'b0) $display("FAIL reset_rf_wen got %b exp 0", rf_wen); else pass_cnt++;
    total++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
      $display("FAIL reset_busy got %b/%b exp 0/0", rs1_busy, rs2_busy); else pass_cnt++;
    exu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk); rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_wb;
    do_issue(5'd5);
    rs1 = 5'd5;
    #1;
    total++; if (rs1_busy !== 1'b1) $display("FAIL single_busy_set got %b exp 1", rs1_busy); else pass_cnt++;
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
    #1;
    total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF || exu_ready !== 1'b1)
      $display("FAIL single_wb got wen=%b addr=%0d data=%h rdy=%b exp 1/5/deadbeef/1",
               rf_wen, rf_waddr, rf_wdata, exu_ready); else pass_cnt++;
    tick();
    exu_valid = 1'b0;
    #1;
    total++; if (rs1_busy !== 1'b0) $display("FAIL single_busy_clr got %b exp 0", rs1_busy); else pass_cnt++;
    total++; if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0)
      $display("FAIL idle_outputs got wen=%b addr=%0d data=%h exp 0/0/0", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
  endtask

  task automatic test_contention;
    do_issue(5'd3);
    do_issue(5'd4);
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'hAAAA_0003;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hBBBB_0004;
    #1;
    total++; if (exu_ready !== 1'b1 || lsu_ready !== 1'b0 || rf_waddr !== 5'd3 || rf_wdata !== 32'hAAAA_0003)
      $display("FAIL cont_c1 got exu=%b lsu=%b addr=%0d data=%h exp 1/0/3/aaaa0003",
               exu_ready, lsu_ready, rf_waddr, rf_wdata); else pass_cnt++;
    tick();
    issue_valid = 1'b1; issue_rd = 5'd3;  // re-arm 3 for the third round
    #1;
    total++; if (exu_ready !== 1'b0 || lsu_ready !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'hBBBB_0004)
      $display("FAIL cont_c2 got exu=%b lsu=%b addr=%0d data=%h exp 0/1/4/bbbb0004",
               exu_ready, lsu_ready, rf_waddr, rf_wdata); else pass_cnt++;
    total++; if (issue_ready !== 1'b1) $display("FAIL cont_reissue got %b exp 1", issue_ready); else pass_cnt++;
    tick();
    issue_valid = 1'b0;
    #1;
    total++; if (exu_ready !== 1'b1 || lsu_ready !== 1'b0 || rf_waddr !== 5'd3)
      $display("FAIL cont_c3 got exu=%b lsu=%b addr=%0d exp 1/0/3", exu_ready, lsu_ready, rf_waddr); else pass_cnt++;
    tick();
    exu_valid = 1'b0; lsu_valid = 1'b0;
    rs1 = 5'd3; rs2 = 5'd4;
    #1;
    total++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
      $display("FAIL cont_busy got %b/%b exp 0/0", rs1_busy, rs2_busy); else pass_cnt++;
  endtask

  task automatic test_x0;
    do_issue(5'd6);
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0000_0123;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    total++; if (lsu_ready !== 1'b1 || rf_wen !== 1'b0)
      $display("FAIL x0_wb got rdy=%b wen=%b exp 1/0", lsu_ready, rf_wen); else pass_cnt++;
    total++; if (issue_ready !== 1'b1) $display("FAIL x0_issue got %b exp 1", issue_ready); else pass_cnt++;
    tick();
    lsu_valid = 1'b0; issue_valid = 1'b0;
    rs1 = 5'd6; rs2 = 5'd0;
    #1;
    total++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0)
      $display("FAIL x0_sb got r6=%b r0=%b exp 1/0", rs1_busy, rs2_busy); else pass_cnt++;
    do_wb(5'd6);
  endtask

  task automatic test_hazard;
    do_issue(5'd7);
    rs1 = 5'd7;
    issue_valid = 1'b1; issue_rd = 5'd7;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (rs1_busy !== 1'b1 || issue_ready !== 1'b0)
        $display("FAIL haz_stall%0d got busy=%b rdy=%b exp 1/0", c, rs1_busy, issue_ready); else pass_cnt++;
      tick();
    end
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h7;
    #1;
    total++; if (issue_ready !== 1'b0 || rs1_busy !== 1'b1 || exu_ready !== 1'b1)
      $display("FAIL haz_clr_cycle got rdy=%b busy=%b exu=%b exp 0/1/1", issue_ready, rs1_busy, exu_ready); else pass_cnt++;
    tick();
    exu_valid = 1'b0;
    #1;
    total++; if (rs1_busy !== 1'b0 || issue_ready !== 1'b1)
      $display("FAIL haz_release got busy=%b rdy=%b exp 0/1", rs1_busy, issue_ready); else pass_cnt++;
    tick();
    issue_valid = 1'b0;
    #1;
    total++; if (rs1_busy !== 1'b1) $display("FAIL haz_reissued got %b exp 1", rs1_busy); else pass_cnt++;
    do_wb(5'd7);
  endtask

  task automatic test_simultaneous;
    do_issue(5'd9);
    exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h9;
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    total++; if (issue_ready !== 1'b0) $display("FAIL sim_same_blocked got %b exp 0", issue_ready); else pass_cnt++;
    tick();
    exu_valid = 1'b0;
    #1;
    total++; if (issue_ready !== 1'b1) $display("FAIL sim_same_next got %b exp 1", issue_ready); else pass_cnt++;
    tick();
    exu_valid = 1'b1; exu_rd = 5'd9;
    issue_valid = 1'b1; issue_rd = 5'd10;
    #1;
    total++; if (issue_ready !== 1'b1 || exu_ready !== 1'b1)
      $display("FAIL sim_diff_hs got issue=%b exu=%b exp 1/1", issue_ready, exu_ready); else pass_cnt++;
    tick();
    exu_valid = 1'b0; issue_valid = 1'b0;
    rs1 = 5'd9; rs2 = 5'd10;
    #1;
    total++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b1)
      $display("FAIL sim_diff_sb got r9=%b r10=%b exp 0/1", rs1_busy, rs2_busy); else pass_cnt++;
    do_wb(5'd10);
  endtask

  task automatic test_reset_mid;
    logic bad;
    for (int r = 1; r < 32; r++) do_issue(5'(r));
    rs1 = 5'd31; rs2 = 5'd1;
    #1;
    total++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1)
      $display("FAIL rmid_all_set got %b/%b exp 1/1", rs1_busy, rs2_busy); else pass_cnt++;
    exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2;
    issue_rd = 5'd31;
    #1 rstn = 1'b0;
    #1;
    total++; if (exu_ready !== 1'b0 || lsu_ready !== 1'b0 || rf_wen !== 1'b0 || issue_ready !== 1'b1)
      $display("FAIL rmid_outputs got exu=%b lsu=%b wen=%b issue=%b exp 0/0/0/1",
               exu_ready, lsu_ready, rf_wen, issue_ready); else pass_cnt++;
    exu_valid = 1'b0; lsu_valid = 1'b0;
    bad = 1'b0;
    for (int r = 0; r < 32; r++) begin
      rs1 = 5'(r);
      #0.1;
      if (rs1_busy !== 1'b0) bad = 1'b1;
    end
    total++; if (bad !== 1'b0) $display("FAIL rmid_busy_cleared got some busy=1 exp all 0"); else pass_cnt++;
    @(negedge clk); rstn = 1'b1;
    tick();
    do_issue(5'd3);
    do_issue(5'd4);
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h3;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h4;
    #1;
    total++; if (exu_ready !== 1'b1 || lsu_ready !== 1'b0)
      $display("FAIL rmid_first_cont got exu=%b lsu=%b exp 1/0", exu_ready, lsu_ready); else pass_cnt++;
    tick();
    exu_valid = 1'b0; lsu_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_wb();
    test_contention();
    test_x0();
    test_hazard();
    test_simultaneous();
    test_reset_mid();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
